// File: rtl/fdiv_bf16.sv
// fdiv_bf16 - iterative bfloat16 divider (result = atdata / btdata).
//
// An 11-step restoring mantissa division followed by round-to-nearest-even.
// Special values and flush-to-zero follow the bf16 multiplier of the same
// datapath: exponent 0 (including denormals) reads as zero, NaN results are
// {sign, FF, 7F}. One operation is in flight at a time; constant latency of
// 13 cycles from accept to result, one accept per 14 cycles.
//
// Ports:
//   clk            in   rising-edge clock
//   rst_n          in   asynchronous active-low reset
//   atdata[15:0]   in   dividend (bf16)
//   a_tvalid       in   dividend valid
//   a_tready       out  dividend ready (high only while idle)
//   btdata[15:0]   in   divisor (bf16)
//   b_tvalid       in   divisor valid
//   b_tready       out  divisor ready (same as a_tready)
//   result_tdata   out  quotient (bf16), zero whenever result_tvalid is low
//   result_tvalid  out  one-cycle pulse per result, no backpressure
module fdiv_bf16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] atdata,
  input  logic        a_tvalid,
  output logic        a_tready,
  input  logic [15:0] btdata,
  input  logic        b_tvalid,
  output logic        b_tready,
  output logic [15:0] result_tdata,
  output logic        result_tvalid
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UNPACK = 2'd1,
    DIV    = 2'd2,
    ROUND  = 2'd3
  } state_t;

  state_t             state_r;
  state_t             state_s;

  logic [15:0]        a_r;
  logic [15:0]        b_r;
  logic               sy_r;
  logic signed [9:0]  ex_r;
  logic [9:0]         rem_r;
  logic [8:0]         div_r;
  logic [10:0]        q_r;
  logic [3:0]         cnt_r;
  logic               res_nan_r;
  logic               res_inf_r;
  logic               res_zero_r;
  logic [15:0]        result_tdata_r;
  logic               result_tvalid_r;

  logic               accept_s;
  logic               a_zero_s, a_inf_s, a_nan_s;
  logic               b_zero_s, b_inf_s, b_nan_s;
  logic               ge_s;
  logic [9:0]         rem_next_s;
  logic [6:0]         mant_s;
  logic               g_s;
  logic               s_s;
  logic               round_up_s;
  logic [7:0]         mant_inc_s;
  logic signed [9:0]  e_pre_s;
  logic signed [9:0]  e_fin_s;
  logic [6:0]         mant_fin_s;
  logic [15:0]        round_result_s;

  assign accept_s      = a_tvalid & b_tvalid & (state_r == IDLE);
  assign a_tready      = (state_r == IDLE);
  assign b_tready      = (state_r == IDLE);
  assign result_tdata  = result_tdata_r;
  assign result_tvalid = result_tvalid_r;

  // Operand classification; exponent 0 is zero regardless of mantissa.
  always_comb begin
    a_zero_s = (a_r[14:7] == 8'h00);
    a_inf_s  = (a_r[14:7] == 8'hFF) && (a_r[6:0] == 7'h00);
    a_nan_s  = (a_r[14:7] == 8'hFF) && (a_r[6:0] != 7'h00);
    b_zero_s = (b_r[14:7] == 8'h00);
    b_inf_s  = (b_r[14:7] == 8'hFF) && (b_r[6:0] == 7'h00);
    b_nan_s  = (b_r[14:7] == 8'hFF) && (b_r[6:0] != 7'h00);
  end

  // One restoring-division step. The shift cannot lose a set bit: a
  // remainder with bit 9 set is always >= the divisor, so it is reduced
  // below 512 before shifting.
  always_comb begin
    ge_s = (rem_r >= {1'b0, div_r});
    if (ge_s) begin
      rem_next_s = (rem_r - {1'b0, div_r}) << 1;
    end else begin
      rem_next_s = rem_r << 1;
    end
  end

  // Normalisation, round-to-nearest-even and result packing.
  always_comb begin
    if (q_r[10]) begin
      mant_s  = q_r[9:3];
      g_s     = q_r[2];
      s_s     = (|q_r[1:0]) | (|rem_r);
      e_pre_s = ex_r;
    end else begin
      mant_s  = q_r[8:2];
      g_s     = q_r[1];
      s_s     = q_r[0] | (|rem_r);
      e_pre_s = ex_r - 10'sd1;
    end
    round_up_s = g_s & (s_s | mant_s[0]);
    mant_inc_s = {1'b0, mant_s} + {7'd0, round_up_s};
    if (mant_inc_s[7]) begin
      mant_fin_s = 7'd0;
      e_fin_s    = e_pre_s + 10'sd1;
    end else begin
      mant_fin_s = mant_inc_s[6:0];
      e_fin_s    = e_pre_s;
    end
    if (res_nan_r) begin
      round_result_s = {sy_r, 8'hFF, 7'h7F};
    end else if (res_inf_r) begin
      round_result_s = {sy_r, 8'hFF, 7'h00};
    end else if (res_zero_r) begin
      round_result_s = {sy_r, 8'h00, 7'h00};
    end else if (e_fin_s >= 10'sd255) begin
      round_result_s = {sy_r, 8'hFF, 7'h00};
    end else if (e_fin_s <= 10'sd0) begin
      round_result_s = {sy_r, 8'h00, 7'h00};
    end else begin
      round_result_s = {sy_r, e_fin_s[7:0], mant_fin_s};
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = UNPACK;
        end else begin
          state_s = IDLE;
        end
      end
      UNPACK: state_s = DIV;
      DIV: begin
        if (cnt_r == 4'd0) begin
          state_s = ROUND;
        end else begin
          state_s = DIV;
        end
      end
      ROUND:   state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Operand latch, unpack and division datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r        <= 16'd0;
      b_r        <= 16'd0;
      sy_r       <= 1'b0;
      ex_r       <= 10'sd0;
      rem_r      <= 10'd0;
      div_r      <= 9'd0;
      q_r        <= 11'd0;
      cnt_r      <= 4'd0;
      res_nan_r  <= 1'b0;
      res_inf_r  <= 1'b0;
      res_zero_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            a_r <= atdata;
            b_r <= btdata;
          end
        end
        UNPACK: begin
          sy_r       <= a_r[15] ^ b_r[15];
          ex_r       <= $signed({2'b00, a_r[14:7]} - {2'b00, b_r[14:7]} + 10'd127);
          rem_r      <= {3'b001, a_r[6:0]};
          div_r      <= {2'b01, b_r[6:0]};
          q_r        <= 11'd0;
          cnt_r      <= 4'd10;
          res_nan_r  <= a_nan_s | b_nan_s | (a_zero_s & b_zero_s) | (a_inf_s & b_inf_s);
          res_inf_r  <= a_inf_s | b_zero_s;
          res_zero_r <= a_zero_s | b_inf_s;
        end
        DIV: begin
          rem_r <= rem_next_s;
          q_r   <= {q_r[9:0], ge_s};
          cnt_r <= cnt_r - 4'd1;
        end
        ROUND: begin
          cnt_r <= 4'd0;
        end
        default: begin
          cnt_r <= 4'd0;
        end
      endcase
    end
  end

  // Registered outputs: loaded only in ROUND, zero in every other cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_tdata_r  <= 16'd0;
      result_tvalid_r <= 1'b0;
    end else if (state_r == ROUND) begin
      result_tdata_r  <= round_result_s;
      result_tvalid_r <= 1'b1;
    end else begin
      result_tdata_r  <= 16'd0;
      result_tvalid_r <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fdiv_bf16.sv
// tb_fdiv_bf16 - self-checking bench for fdiv_bf16: a vector table of
// directed quotients plus hand-written handshake and reset sequences.
module tb_fdiv_bf16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] atdata;
  logic        a_tvalid;
  logic        a_tready;
  logic [15:0] btdata;
  logic        b_tvalid;
  logic        b_tready;
  logic [15:0] result_tdata;
  logic        result_tvalid;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] q;
  } vec_t;

  vec_t vecs [0:11];

  fdiv_bf16 dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .atdata        (atdata),
    .a_tvalid      (a_tvalid),
    .a_tready      (a_tready),
    .btdata        (btdata),
    .b_tvalid      (b_tvalid),
    .b_tready      (b_tready),
    .result_tdata  (result_tdata),
    .result_tvalid (result_tvalid)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
    end
  endtask

  // One full operation: accept, latency, quiet outputs while busy, result, pulse width.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] exp, input int idx);
    int   lat;
    logic busy_bad;
    @(negedge clk);
    check($sformatf("v%0d ready_idle", idx), {a_tready, b_tready}, 2'b11);
    atdata   = a;
    btdata   = b;
    a_tvalid = 1'b1;
    b_tvalid = 1'b1;
    @(posedge clk);
    #1;
    a_tvalid = 1'b0;
    b_tvalid = 1'b0;
    atdata   = 16'hFFFF;
    btdata   = 16'h0000;
    lat      = 0;
    busy_bad = 1'b0;
    if (a_tready | b_tready | result_tvalid) busy_bad = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (result_tvalid) begin
        lat = k;
        break;
      end
      if (a_tready | b_tready | (result_tdata != 16'd0)) busy_bad = 1'b1;
    end
    check($sformatf("v%0d latency", idx), lat, 13);
    check($sformatf("v%0d busy_quiet", idx), busy_bad, 1'b0);
    check($sformatf("v%0d quotient", idx), result_tdata, exp);
    check($sformatf("v%0d ready_at_result", idx), a_tready, 1'b1);
    @(posedge clk);
    #1;
    check($sformatf("v%0d pulse_end", idx), {result_tvalid, result_tdata}, 17'd0);
  endtask

  initial begin
    int   acc_cyc [3];
    int   res_cyc [3];
    logic [15:0] res_dat [3];
    int   acc_n;
    int   res_n;
    int   bad;
    logic acc_now;

    vecs[0]  = '{a: 16'h3FC0, b: 16'h3F00, q: 16'h4040};
    vecs[1]  = '{a: 16'h3F80, b: 16'h4040, q: 16'h3EAB};
    vecs[2]  = '{a: 16'hBF80, b: 16'h3F80, q: 16'hBF80};
    vecs[3]  = '{a: 16'h4000, b: 16'h0000, q: 16'h7F80};
    vecs[4]  = '{a: 16'h0000, b: 16'h0000, q: 16'h7FFF};
    vecs[5]  = '{a: 16'hFF80, b: 16'h4000, q: 16'hFF80};
    vecs[6]  = '{a: 16'h7FC1, b: 16'h3F80, q: 16'h7FFF};
    vecs[7]  = '{a: 16'h3F80, b: 16'h7F80, q: 16'h0000};
    vecs[8]  = '{a: 16'h7F00, b: 16'h3E80, q: 16'h7F80};
    vecs[9]  = '{a: 16'h0080, b: 16'h4000, q: 16'h0000};
    vecs[10] = '{a: 16'h0001, b: 16'h3F80, q: 16'h0000};
    vecs[11] = '{a: 16'hC0A0, b: 16'hBFC0, q: 16'h4055};

    rst_n    = 1'b0;
    atdata   = 16'd0;
    btdata   = 16'd0;
    a_tvalid = 1'b0;
    b_tvalid = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {a_tready, b_tready, result_tvalid, result_tdata}, {2'b11, 17'd0});
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vector table.
    for (int i = 0; i < 12; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].q, i);
    end

    // Back-to-back: valids held high, operands swapped while busy.
    for (int i = 0; i < 3; i++) begin
      acc_cyc[i] = -1;
      res_cyc[i] = -1;
      res_dat[i] = 16'hDEAD;
    end
    acc_n = 0;
    res_n = 0;
    @(negedge clk);
    atdata   = vecs[0].a;
    btdata   = vecs[0].b;
    a_tvalid = 1'b1;
    b_tvalid = 1'b1;
    for (int c = 0; c < 50; c++) begin
      acc_now = a_tready & a_tvalid & b_tvalid;
      @(posedge clk);
      #1;
      if (result_tvalid) begin
        if (res_n < 3) begin
          res_cyc[res_n] = c;
          res_dat[res_n] = result_tdata;
        end
        res_n++;
      end
      if (acc_now) begin
        if (acc_n < 3) acc_cyc[acc_n] = c;
        acc_n++;
        if (acc_n < 3) begin
          atdata = vecs[acc_n].a;
          btdata = vecs[acc_n].b;
        end else begin
          a_tvalid = 1'b0;
          b_tvalid = 1'b0;
        end
      end
      @(negedge clk);
    end
    check("b2b_accepts", acc_n, 3);
    check("b2b_results", res_n, 3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("b2b_accept_cycle%0d", i), acc_cyc[i], 14 * i);
      check($sformatf("b2b_result_cycle%0d", i), res_cyc[i], 14 * i + 13);
      check($sformatf("b2b_quotient%0d", i), res_dat[i], vecs[i].q);
    end

    // Dividend valid alone must never be accepted.
    @(negedge clk);
    atdata   = 16'h3F80;
    btdata   = 16'h3F80;
    a_tvalid = 1'b1;
    b_tvalid = 1'b0;
    bad = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (!a_tready || result_tvalid) bad++;
    end
    a_tvalid = 1'b0;
    check("single_valid_ignored", bad, 0);

    // Reset during DIV aborts the operation.
    @(negedge clk);
    atdata   = 16'h3F80;
    btdata   = 16'h4040;
    a_tvalid = 1'b1;
    b_tvalid = 1'b1;
    @(posedge clk);
    #1;
    a_tvalid = 1'b0;
    b_tvalid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    check("pre_reset_busy", a_tready, 1'b0);
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {a_tready, b_tready, result_tvalid, result_tdata}, {2'b11, 17'd0});
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (result_tvalid || !a_tready) bad++;
    end
    check("no_stray_after_reset", bad, 0);
    do_op(16'h3FC0, 16'h3F00, 16'h4040, 99);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fdiv_bf16.md
# fdiv_bf16

Iterative bfloat16 divider. It computes `atdata / btdata` using an 11-step restoring mantissa division with round-to-nearest-even. It sits beside the pipelined bf16 multiplier in the `tiny_glut` arithmetic datapath and follows the multiplier's special-value and flush-to-zero rules. Because the divider is iterative, it adds input-side ready signals and accepts one operation per 14 cycles.

## Interface
- Parameters: none.
- `clk`  in  1  Single clock, rising edge.
- `rst_n`  in  1  Asynchronous, active-low reset.
- `atdata`  in  16  Dividend, bf16 format: sign [15], exponent [14:7], mantissa [6:0].
- `a_tvalid`  in  1  Dividend valid.
- `a_tready`  out  1  Dividend ready; equals (state == IDLE).
- `btdata`  in  16  Divisor, bf16 format.
- `b_tvalid`  in  1  Divisor valid.
- `b_tready`  out  1  Divisor ready; identical to `a_tready`.
- `result_tdata`  out  16  Quotient, bf16. Driven to 0 whenever `result_tvalid` is 0.
- `result_tvalid`  out  1  One-cycle pulse per result. There is no output backpressure.

## Operation
- **Accept condition:** `a_tvalid & b_tvalid & a_tready` at a rising edge. A single valid without the other is never accepted.
- **On accept:** latch sign, exponent and mantissa of both operands. Go to UNPACK.
- **UNPACK** (1 cycle):
  - `sy = sa ^ sb`.
  - 10-bit signed `ex = ea - eb + 127`.
  - `rem = {1, ma}` (9 bits), `div = {1, mb}`.
  - Classify specials. Exponent 0 is treated as zero, including denormals.
  - Go to DIV.
- **DIV** (11 cycles, counter 10 down to 0). Each cycle:
  - If `rem >= div`: write quotient bit 1 and set `rem -= div`; otherwise write bit 0.
  - Then shift `rem` left by 1.
  - Quotient bits fill `q[10]` down to `q[0]`.
  - After count 0, go to ROUND.
- **ROUND** (1 cycle). Register the result, pulse `result_tvalid`, return to IDLE.
  - **Normalisation**, with `st = |rem`:
    - If `q[10]`: `mant = q[9:3]`, `g = q[2]`, `s = |q[1:0] | st`, `e = ex`.
    - Else: `mant = q[8:2]`, `g = q[1]`, `s = q[0] | st`, `e = ex - 1`.
  - **Rounding:** round up when `g & (s | mant[0])`. A mantissa carry-out increments `e` and sets the mantissa to 0.
  - **Range:** `e >= 255` → `{sy, FF, 00}` (infinity). `e <= 0` → `{sy, 00, 00}` (flush to zero).
  - **Special priority**, highest first:
    1. NaN operand, 0/0, or inf/inf → `{sy, FF, 7F}`.
    2. inf/x or x/0 → `{sy, FF, 00}`.
    3. 0/x or x/inf → `{sy, 00, 00}`.
  - Specials still traverse DIV, so latency is constant.
- **Reset:**
  - State IDLE; counter, quotient and remainder cleared.
  - `result_tdata = 0`, `result_tvalid = 0`.
  - `a_tready = b_tready = 1` (combinational from IDLE).
  - Reset asserted mid-operation aborts it with no `result_tvalid`.

## Timing
- Accept at edge T. UNPACK register at T+1. DIV iterations at edges T+2 through T+12. ROUND at T+13.
- `result_tvalid` is high for exactly the cycle after edge T+13.
- Ready deasserts in the cycle after edge T. It reasserts in the cycle after edge T+13.
- Earliest next accept is edge T+14, giving a throughput of 1 per 14 cycles.
- Input changes while ready is low are ignored. The latched operands are not disturbed.
- Output state updates only at ROUND. In every other cycle `result_tdata` is 0.

## Test plan
- **Basic quotient:** `0x3FC0 / 0x3F00` (1.5/0.5) → `0x4040`.
  - `result_tvalid` pulses exactly 13 cycles after accept.
  - `a_tready` is low in the 13 cycles between accept and the result.
- **Rounding and normalisation:** `0x3F80 / 0x4040` (1/3) → `0x3EAB`.
  - Exercises the `q[10] = 0` normalisation path and a round-up.
  - `0xBF80 / 0x3F80` → `0xBF80` (sign path).
- **Specials:**
  - `0x4000 / 0x0000` → `0x7F80`.
  - `0x0000 / 0x0000` → `0x7FFF`.
  - `0xFF80 / 0x4000` → `0xFF80`.
  - `0x7FC1 / 0x3F80` → `0x7FFF`.
  - `0x3F80 / 0x7F80` → `0x0000`.
- **Range limits:**
  - `0x7F00 / 0x3E80` → `0x7F80` (overflow).
  - `0x0080 / 0x4000` → `0x0000` (underflow flush).
  - `0x0001 / 0x3F80` → `0x0000` (denormal input treated as zero).
- **Handshake:**
  - Hold both valids high with three operand pairs → accepts at edges T, T+14, T+28, and three result pulses.
  - `a_tvalid = 1` with `b_tvalid = 0` for 20 cycles → no accept, no result.
- **Reset mid-operation:**
  - Drop `rst_n` asynchronously during DIV → outputs go to 0 immediately and ready reads 1.
  - After release, no stray `result_tvalid`.
  - A new operation completes normally.
